rob_ctrl: RTL and testbench

Reorder-buffer controller for the 2-wide out-of-order core. It owns the ROB head and tail pointers and per-entry status bits, and supplies `rob_tail`/`rob_head` to dispatch. Each cycle it allocates up to two entries in program order, marks entries complete from three writeback ports (complex, simple, fp), and retires up to two completed entries in order. It also handles branch-mispredict flushes and exceptions raised at the head.

---
 rtl/rob_ctrl.sv | 154 +++++++++++++++
 tb/tb_rob_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer head/tail and per-entry status tracking for a
// 2-wide core. Allocates up to two entries per cycle in program order,
// completes entries from three writeback ports, retires up to two completed
// entries in order, and handles branch-mispredict flushes and head exceptions.
//
// Strobe semantics: alloc_*, wbN_valid and flush_valid are single-cycle
// qualifiers sampled at the rising edge, with no back-pressure. Dispatch
// must keep alloc within free space. commit_*_valid and exc_valid are
// combinational views of the current state. They act at the next edge and
// need no acknowledge.
module rob_ctrl #(
  parameter int ENTRIES = 16,
  parameter int PTR_W   = 4,
  parameter int RD_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_A,
  input  logic             alloc_B,
  input  logic [RD_W-1:0]  alloc_rd_A,
  input  logic [RD_W-1:0]  alloc_rd_B,
  input  logic             alloc_rw_A,
  input  logic             alloc_rw_B,
  input  logic             wb0_valid,
  input  logic             wb1_valid,
  input  logic             wb2_valid,
  input  logic [PTR_W-1:0] wb0_idx,
  input  logic [PTR_W-1:0] wb1_idx,
  input  logic [PTR_W-1:0] wb2_idx,
  input  logic             wb0_exc,
  input  logic             wb1_exc,
  input  logic             wb2_exc,
  input  logic             flush_valid,
  input  logic [PTR_W-1:0] flush_idx,
  output logic [PTR_W-1:0] rob_tail,
  output logic [PTR_W-1:0] rob_head,
  output logic [PTR_W:0]   rob_count,
  output logic             commit_A_valid,
  output logic             commit_B_valid,
  output logic [RD_W-1:0]  commit_A_rd,
  output logic [RD_W-1:0]  commit_B_rd,
  output logic             commit_A_rw,
  output logic             commit_B_rw,
  output logic             exc_valid,
  output logic [PTR_W-1:0] exc_idx
);

  logic [ENTRIES-1:0] valid_q, done_q, exc_q, rw_q;
  logic [RD_W-1:0]    rd_q [ENTRIES];
  logic [PTR_W-1:0]   head_q, tail_q;

  logic [PTR_W-1:0]   head_p1, used, b_idx;
  logic [PTR_W:0]     free_cnt;
  logic               do_a, do_b, flush_at_head;
  logic [ENTRIES-1:0] kill;

  // Occupancy is derived from the pre-edge pointers only, so a slot freed by
  // this cycle's commit is never handed out again in the same cycle.
  assign head_p1  = head_q + PTR_W'(1);
  assign used     = tail_q - head_q;
  assign free_cnt = (PTR_W+1)'(ENTRIES - 1) - {1'b0, used};
  assign do_a     = alloc_A && (free_cnt != '0);
  assign do_b     = alloc_B && (free_cnt > {{PTR_W{1'b0}}, alloc_A});
  assign b_idx    = tail_q + PTR_W'(alloc_A);

  assign rob_tail  = tail_q;
  assign rob_head  = head_q;
  assign rob_count = {1'b0, used};

  // If the mispredicted branch sits at head, the entry after it is wrong-path
  // and must not retire alongside the branch.
  assign flush_at_head  = flush_valid && (flush_idx == head_q);
  assign commit_A_valid = valid_q[head_q] & done_q[head_q] & ~exc_q[head_q];
  assign commit_B_valid = commit_A_valid & valid_q[head_p1] & done_q[head_p1]
                          & ~exc_q[head_p1] & ~flush_at_head;
  assign commit_A_rd    = rd_q[head_q];
  assign commit_A_rw    = rw_q[head_q];
  assign commit_B_rd    = rd_q[head_p1];
  assign commit_B_rw    = rw_q[head_p1];
  assign exc_valid      = valid_q[head_q] & done_q[head_q] & exc_q[head_q];
  assign exc_idx        = head_q;

  // Mark entries strictly younger than the branch, up to tail-1, for flushing.
  // Offsets are taken relative to head so the comparisons survive wrap-around.
  always_comb begin
    logic [PTR_W-1:0] off;
    logic [PTR_W-1:0] flush_off;
    kill      = '0;
    off       = '0;
    flush_off = flush_idx - head_q;
    for (int i = 0; i < ENTRIES; i++) begin
      off = PTR_W'(i) - head_q;
      if ((off > flush_off) && (off < used)) kill[i] = 1'b1;
    end
  end

  // State update. Priority: reset, head exception, flush, then the
  // combined alloc / writeback / commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      rw_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (exc_valid) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      if (wb0_valid && valid_q[wb0_idx]) begin
        done_q[wb0_idx] <= 1'b1;
        exc_q[wb0_idx]  <= exc_q[wb0_idx] | wb0_exc;
      end
      if (wb1_valid && valid_q[wb1_idx]) begin
        done_q[wb1_idx] <= 1'b1;
        exc_q[wb1_idx]  <= exc_q[wb1_idx] | wb1_exc;
      end
      if (wb2_valid && valid_q[wb2_idx]) begin
        done_q[wb2_idx] <= 1'b1;
        exc_q[wb2_idx]  <= exc_q[wb2_idx] | wb2_exc;
      end
      if (commit_A_valid) valid_q[head_q]  <= 1'b0;
      if (commit_B_valid) valid_q[head_p1] <= 1'b0;
      head_q <= head_q + PTR_W'(commit_A_valid) + PTR_W'(commit_B_valid);
      if (flush_valid) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (kill[i]) valid_q[i] <= 1'b0;
        end
        tail_q <= flush_idx + PTR_W'(1);
      end else begin
        if (do_a) begin
          valid_q[tail_q] <= 1'b1;
          done_q[tail_q]  <= 1'b0;
          exc_q[tail_q]   <= 1'b0;
          rd_q[tail_q]    <= alloc_rd_A;
          rw_q[tail_q]    <= alloc_rw_A;
        end
        if (do_b) begin
          valid_q[b_idx] <= 1'b1;
          done_q[b_idx]  <= 1'b0;
          exc_q[b_idx]   <= 1'b0;
          rd_q[b_idx]    <= alloc_rd_B;
          rw_q[b_idx]    <= alloc_rw_B;
        end
        tail_q <= tail_q + PTR_W'(do_a) + PTR_W'(do_b);
      end
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: directed scenarios plus a random phase for rob_ctrl. Every
// allocation pushes its {idx, rw, rd} onto exp_q. Each retirement pops the
// oldest record and compares it. Pointer and occupancy checks use values
// the bench derives itself.
module tb_rob_ctrl;

  localparam int ENTRIES = 16;
  localparam int PTR_W   = 4;
  localparam int RD_W    = 5;
  localparam int EW      = PTR_W + 1 + RD_W;

  logic             clk;
  logic             rst;
  logic             alloc_A, alloc_B;
  logic [RD_W-1:0]  alloc_rd_A, alloc_rd_B;
  logic             alloc_rw_A, alloc_rw_B;
  logic             wb0_valid, wb1_valid, wb2_valid;
  logic [PTR_W-1:0] wb0_idx, wb1_idx, wb2_idx;
  logic             wb0_exc, wb1_exc, wb2_exc;
  logic             flush_valid;
  logic [PTR_W-1:0] flush_idx;
  logic [PTR_W-1:0] rob_tail, rob_head;
  logic [PTR_W:0]   rob_count;
  logic             commit_A_valid, commit_B_valid;
  logic [RD_W-1:0]  commit_A_rd, commit_B_rd;
  logic             commit_A_rw, commit_B_rw;
  logic             exc_valid;
  logic [PTR_W-1:0] exc_idx;

  logic [EW-1:0]    exp_q[$];
  logic [PTR_W-1:0] pend_q[$];
  logic [PTR_W-1:0] m_tail;
  int               n_tests;
  int               n_fail;

  rob_ctrl #(.ENTRIES(ENTRIES), .PTR_W(PTR_W), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_A(alloc_A), .alloc_B(alloc_B),
    .alloc_rd_A(alloc_rd_A), .alloc_rd_B(alloc_rd_B),
    .alloc_rw_A(alloc_rw_A), .alloc_rw_B(alloc_rw_B),
    .wb0_valid(wb0_valid), .wb1_valid(wb1_valid), .wb2_valid(wb2_valid),
    .wb0_idx(wb0_idx), .wb1_idx(wb1_idx), .wb2_idx(wb2_idx),
    .wb0_exc(wb0_exc), .wb1_exc(wb1_exc), .wb2_exc(wb2_exc),
    .flush_valid(flush_valid), .flush_idx(flush_idx),
    .rob_tail(rob_tail), .rob_head(rob_head), .rob_count(rob_count),
    .commit_A_valid(commit_A_valid), .commit_B_valid(commit_B_valid),
    .commit_A_rd(commit_A_rd), .commit_B_rd(commit_B_rd),
    .commit_A_rw(commit_A_rw), .commit_B_rw(commit_B_rw),
    .exc_valid(exc_valid), .exc_idx(exc_idx)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    alloc_A = 0; alloc_B = 0; alloc_rd_A = '0; alloc_rd_B = '0;
    alloc_rw_A = 0; alloc_rw_B = 0;
    wb0_valid = 0; wb1_valid = 0; wb2_valid = 0;
    wb0_idx = '0; wb1_idx = '0; wb2_idx = '0;
    wb0_exc = 0; wb1_exc = 0; wb2_exc = 0;
    flush_valid = 0; flush_idx = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 0;
    exp_q.delete();
    pend_q.delete();
    m_tail = '0;
  endtask

  task automatic drive_alloc(input bit a, input bit b);
    logic [RD_W-1:0] rd;
    logic            rw;
    if (a) begin
      rd = RD_W'($urandom_range(0, 31));
      rw = 1'($urandom_range(0, 1));
      alloc_A = 1; alloc_rd_A = rd; alloc_rw_A = rw;
      exp_q.push_back({m_tail, rw, rd});
      m_tail = m_tail + 1'b1;
    end
    if (b) begin
      rd = RD_W'($urandom_range(0, 31));
      rw = 1'($urandom_range(0, 1));
      alloc_B = 1; alloc_rd_B = rd; alloc_rw_B = rw;
      exp_q.push_back({m_tail, rw, rd});
      m_tail = m_tail + 1'b1;
    end
  endtask

  task automatic drive_wb(input int port, input logic [PTR_W-1:0] idx, input bit exc);
    case (port)
      0: begin wb0_valid = 1; wb0_idx = idx; wb0_exc = exc; end
      1: begin wb1_valid = 1; wb1_idx = idx; wb1_exc = exc; end
      default: begin wb2_valid = 1; wb2_idx = idx; wb2_exc = exc; end
    endcase
  endtask

  task automatic wait_head(input logic [PTR_W-1:0] h, input string tag);
    int n;
    n = 0;
    while (rob_head !== h && n < 40) begin
      tick();
      n++;
    end
    check(tag, rob_head, h);
  endtask

  task automatic pop_check(input string tag, input logic [PTR_W-1:0] idx,
                           input logic rw, input logic [RD_W-1:0] rd);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {idx, rw, rd}, e);
    end
  endtask

  // Scoreboard: retirements must match allocations in program order
  always @(negedge clk) begin
    if (!rst) begin
      if (commit_A_valid) pop_check("commit_A", rob_head, commit_A_rw, commit_A_rd);
      if (commit_B_valid) pop_check("commit_B", rob_head + 4'd1, commit_B_rw, commit_B_rd);
      if (exc_valid) exp_q.delete();
    end
  end

  initial begin
    logic [EW-1:0]    e;
    logic [PTR_W-1:0] new_idx[$];
    int               free;
    bit               a, b;
    int               nw, j;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1;
    m_tail  = '0;
    clear_inputs();
    repeat (2) @(posedge clk);
    do_reset();

    // Reset state
    check("reset_tail", rob_tail, 0);
    check("reset_head", rob_head, 0);
    check("reset_count", rob_count, 0);
    check("reset_commit_A", commit_A_valid, 0);
    check("reset_commit_B", commit_B_valid, 0);
    check("reset_exc", exc_valid, 0);

    // Fill without writebacks up to the 15-entry capacity
    for (int k = 0; k < 7; k++) begin
      drive_alloc(1, 1);
      tick();
      check("fill_tail", rob_tail, 2 * (k + 1));
    end
    drive_alloc(1, 0);
    tick();
    check("fill_tail_last", rob_tail, 15);
    check("fill_count", rob_count, 15);
    check("fill_no_commit", commit_A_valid, 0);

    // Out-of-order writeback, paired retirement
    do_reset();
    drive_alloc(1, 1); tick();
    drive_alloc(1, 1); tick();
    drive_wb(1, 4'd1, 0); tick();
    check("pair_wait", commit_A_valid, 0);
    drive_wb(0, 4'd0, 0); tick();
    check("pair_A", commit_A_valid, 1);
    check("pair_B", commit_B_valid, 1);
    tick();
    check("pair_head", rob_head, 2);
    check("pair_count", rob_count, 2);

    // Wrap-around: head at 14, tail wrapped to 2
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive_alloc(1, 1);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      for (int p = 0; p < 3; p++) begin
        if (3 * k + p < 14) drive_wb(p, PTR_W'(3 * k + p), 0);
      end
      tick();
    end
    wait_head(4'd14, "wrap_drain_head");
    drive_alloc(1, 1); tick();
    drive_alloc(1, 1); tick();
    check("wrap_tail", rob_tail, 2);
    check("wrap_count_full", rob_count, 4);
    drive_wb(0, 4'd14, 0);
    drive_wb(1, 4'd15, 0);
    tick();
    check("wrap_A", commit_A_valid, 1);
    check("wrap_B", commit_B_valid, 1);
    tick();
    check("wrap_head", rob_head, 0);
    check("wrap_count", rob_count, 2);

    // Flush at idx 2 overrides a simultaneous alloc
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive_alloc(1, 1);
      tick();
    end
    flush_valid = 1; flush_idx = 4'd2;
    alloc_A = 1; alloc_rd_A = 5'd7; alloc_rw_A = 1;
    while (exp_q.size() > 0) begin
      e = exp_q[$];
      if (e[EW-1 -: PTR_W] == 4'd2) break;
      void'(exp_q.pop_back());
    end
    m_tail = 4'd3;
    tick();
    check("flush_tail", rob_tail, 3);
    check("flush_count", rob_count, 3);
    drive_wb(0, 4'd3, 0);
    drive_wb(1, 4'd4, 0);
    tick();
    drive_wb(0, 4'd0, 0);
    drive_wb(1, 4'd1, 0);
    drive_wb(2, 4'd2, 0);
    tick();
    wait_head(4'd3, "flush_head");
    tick();
    tick();
    check("flush_no_commit", commit_A_valid, 0);
    check("flush_count_end", rob_count, 0);

    // Exception at head clears everything, alloc in that cycle is ignored
    do_reset();
    drive_alloc(1, 1); tick();
    drive_wb(2, 4'd0, 1); tick();
    check("exc_valid", exc_valid, 1);
    check("exc_idx", exc_idx, 0);
    check("exc_no_commit", commit_A_valid, 0);
    drive_alloc(1, 0);
    tick();
    m_tail = '0;
    check("exc_clear", exc_valid, 0);
    check("exc_head", rob_head, 0);
    check("exc_tail", rob_tail, 0);
    check("exc_count", rob_count, 0);

    // Writeback to the entry being allocated in the same cycle is ignored
    do_reset();
    drive_alloc(1, 1); tick();
    drive_alloc(1, 0); tick();
    drive_alloc(1, 0);
    drive_wb(1, 4'd3, 0);
    tick();
    drive_wb(0, 4'd0, 0);
    drive_wb(1, 4'd1, 0);
    drive_wb(2, 4'd2, 0);
    tick();
    wait_head(4'd3, "same_head");
    tick();
    check("same_no_commit", commit_A_valid, 0);
    check("same_count", rob_count, 1);
    drive_wb(0, 4'd3, 0);
    tick();
    check("same_commit", commit_A_valid, 1);
    tick();
    check("same_count_end", rob_count, 0);

    // Random traffic with dispatch-style blocking
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      check("rnd_count", rob_count, exp_q.size());
      free = 15 - exp_q.size();
      a = ($urandom_range(0, 1) == 1) && (free >= 1);
      b = ($urandom_range(0, 1) == 1) && (free >= 1 + int'(a));
      new_idx.delete();
      if (a) new_idx.push_back(m_tail);
      if (b) new_idx.push_back(m_tail + 4'(a));
      drive_alloc(a, b);
      nw = $urandom_range(0, 3);
      for (int p = 0; p < nw; p++) begin
        if (pend_q.size() > 0) begin
          j = $urandom_range(0, pend_q.size() - 1);
          drive_wb(p, pend_q[j], 0);
          pend_q.delete(j);
        end
      end
      tick();
      foreach (new_idx[k]) pend_q.push_back(new_idx[k]);
    end
    while (pend_q.size() > 0) begin
      for (int p = 0; p < 3; p++) begin
        if (pend_q.size() > 0) drive_wb(p, pend_q.pop_front(), 0);
      end
      tick();
    end
    for (int k = 0; k < 40 && rob_count != 0; k++) tick();
    check("drain_count", rob_count, 0);
    check("drain_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
